// File: rtl/mips_pkg.sv
// Shared opcode, ALU/mux encodings, state enum and control-word layout for the
// multicycle MIPS control FSM.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_write;
        logic       branch;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Combinational state -> control-word decode; FETCH strobes follow mem_ready.
module multicycle_control_outdec
    import mips_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.memto_reg = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADDI;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: next-state logic, retired-instruction counter,
// and reset gating of the write/read strobes around the output decoder.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    state_t           w_next;
    logic             w_retire;
    ctrl_t            w_ctrl;

    multicycle_control_outdec u_outdec (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_ADDIEX:   w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // An illegal opcode also returns to FETCH from DECODE, so DECODE is excluded.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                w_retire = (w_next == S_FETCH);
            default: w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read & rst_n;
    assign MemWrite    = w_ctrl.mem_write & rst_n;
    assign IRWrite     = w_ctrl.ir_write & rst_n;
    assign RegDst      = w_ctrl.reg_dst;
    assign MemtoReg    = w_ctrl.memto_reg;
    assign RegWrite    = w_ctrl.reg_write & rst_n;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign PCWrite     = w_ctrl.pc_write & rst_n;
    assign Branch      = w_ctrl.branch;
    assign ALUOp       = w_ctrl.alu_op;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign PCSrc       = w_ctrl.pc_src;
    assign illegal_op  = rst_n & (r_state == S_DECODE) & ~is_legal_op(opcode);
    assign instr_count = r_count;
    assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: each instruction is expanded into the state
// path it must walk, and every cycle's outputs are compared to the control table.
module tb_multicycle_control;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic        ALUSrcA, PCWrite, Branch, illegal_op;
    logic [1:0]  ALUOp, ALUSrcB, PCSrc;
    logic [31:0] instr_count;
    logic [3:0]  state;

    logic        d4_IorD, d4_MemRead, d4_MemWrite, d4_IRWrite, d4_RegDst, d4_MemtoReg;
    logic        d4_RegWrite, d4_ALUSrcA, d4_PCWrite, d4_Branch, d4_illegal_op;
    logic [1:0]  d4_ALUOp, d4_ALUSrcB, d4_PCSrc;
    logic [3:0]  d4_instr_count;
    logic [3:0]  d4_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned m_cnt = 0;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .Branch(Branch), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(d4_IorD), .MemRead(d4_MemRead), .MemWrite(d4_MemWrite), .IRWrite(d4_IRWrite),
        .RegDst(d4_RegDst), .MemtoReg(d4_MemtoReg), .RegWrite(d4_RegWrite),
        .ALUSrcA(d4_ALUSrcA), .PCWrite(d4_PCWrite), .Branch(d4_Branch), .ALUOp(d4_ALUOp),
        .ALUSrcB(d4_ALUSrcB), .PCSrc(d4_PCSrc), .illegal_op(d4_illegal_op),
        .instr_count(d4_instr_count), .state(d4_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite
    // ALUSrcA PCWrite Branch ALUOp ALUSrcB PCSrc illegal_op
    wire [16:0] w_obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                         ALUSrcA, PCWrite, Branch, ALUOp, ALUSrcB, PCSrc, illegal_op};
    wire [16:0] w_obs4 = {d4_IorD, d4_MemRead, d4_MemWrite, d4_IRWrite, d4_RegDst,
                          d4_MemtoReg, d4_RegWrite, d4_ALUSrcA, d4_PCWrite, d4_Branch,
                          d4_ALUOp, d4_ALUSrcB, d4_PCSrc, d4_illegal_op};

    function automatic logic [16:0] exp_outs(input state_t s, input logic mr,
                                             input logic [5:0] op, input logic rst_ok);
        logic iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, br, ill;
        logic [1:0] aop, srcb, pcs;
        {iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, br, ill} = '0;
        {aop, srcb, pcs} = '0;
        case (s)
            S_FETCH:    begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE:   begin srcb = 2'b11; ill = !(op inside {6'b100011, 6'b101011,
                              6'b000000, 6'b000100, 6'b001000, 6'b000010}); end
            S_MEMADR:   begin srca = 1; srcb = 2'b10; end
            S_MEMREAD:  begin iord = 1; mrd = 1; end
            S_MEMWB:    begin m2r = 1; rw = 1; end
            S_MEMWRITE: begin iord = 1; mwr = 1; end
            S_EXECUTE:  begin srca = 1; aop = 2'b10; end
            S_ALUWB:    begin rdst = 1; rw = 1; end
            S_BRANCH:   begin srca = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            S_ADDIEX:   begin srca = 1; srcb = 2'b10; aop = 2'b11; end
            S_ADDIWB:   begin rw = 1; end
            S_JUMP:     begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (!rst_ok) {pcw, irw, rw, mwr, mrd, ill} = '0;
        return {iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, br, aop, srcb, pcs, ill};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt32"}, 64'(instr_count), 64'(m_cnt));
        check({tag, "_cnt4"}, 64'(d4_instr_count), 64'(m_cnt[3:0]));
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic do_reset();
        logic mr;
        rst_n = 1'b0;
        mr = 1'($urandom);
        mem_ready = mr;
        opcode = 6'($urandom);
        #1;
        check("rst_strobes", 64'({PCWrite, IRWrite, RegWrite, MemWrite, MemRead, illegal_op}), 64'd0);
        @(posedge clk); #1;
        check("rst_state", 64'(state), 64'(S_FETCH));
        check("rst_outs", 64'(w_obs), 64'(exp_outs(S_FETCH, mr, opcode, 1'b0)));
        m_cnt = 0;
        check_counts("rst");
        rst_n = 1'b1;
    endtask

    // Walk one instruction's path; in fixed mode mem states stall stall_n cycles
    // (FETCH never stalls), in random mode mem_ready is random with a stall cap.
    task automatic run_instr(input logic [5:0] op, input bit rnd, input int stall_n);
        state_t path[$];
        int idx = 0;
        int consec = 0;
        int stalls_left = stall_n;
        bit is_mem;
        logic mr;
        state_t s;
        path.push_back(S_FETCH);
        path.push_back(S_DECODE);
        case (op)
            OP_LW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMREAD); path.push_back(S_MEMWB); end
            OP_SW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMWRITE); end
            OP_RTYPE: begin path.push_back(S_EXECUTE); path.push_back(S_ALUWB); end
            OP_BEQ:   path.push_back(S_BRANCH);
            OP_ADDI:  begin path.push_back(S_ADDIEX); path.push_back(S_ADDIWB); end
            OP_J:     path.push_back(S_JUMP);
            default: ;
        endcase
        while (idx < path.size()) begin
            s = path[idx];
            is_mem = (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
            if (rnd)
                mr = (consec >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            else if (is_mem && s != S_FETCH && stalls_left > 0) begin
                mr = 1'b0;
                stalls_left--;
            end else
                mr = 1'b1;
            mem_ready = mr;
            opcode = (s == S_FETCH) ? 6'($urandom) : op;
            #1;
            check($sformatf("op%02h_%s_state", op, s.name()), 64'(state), 64'(s));
            check($sformatf("op%02h_%s_outs", op, s.name()), 64'(w_obs), 64'(exp_outs(s, mr, op, 1'b1)));
            check($sformatf("op%02h_%s_outs4", op, s.name()), 64'(w_obs4), 64'(exp_outs(s, mr, op, 1'b1)));
            if (!is_mem || mr) begin
                idx++;
                consec = 0;
            end else
                consec++;
            @(posedge clk); #1;
        end
        if (op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J})
            m_cnt++;
        check_counts($sformatf("op%02h_end", op));
    endtask

    logic [5:0] legal_ops [6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};

    initial begin
        logic [5:0] op;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'd0;
        @(posedge clk); #1;
        do_reset();

        run_instr(OP_LW, 1'b0, 0);
        run_instr(OP_RTYPE, 1'b0, 0);
        run_instr(OP_SW, 1'b0, 3);
        run_instr(6'b111111, 1'b0, 0);
        run_instr(OP_BEQ, 1'b0, 0);
        run_instr(OP_ADDI, 1'b0, 0);
        run_instr(OP_J, 1'b0, 0);
        run_instr(OP_LW, 1'b0, 2);

        // Reset lands while a load is stalled in MEMREAD.
        mem_ready = 1'b1; opcode = OP_LW;
        repeat (3) begin @(posedge clk); #1; end
        check("midrd_in_memread", 64'(state), 64'(S_MEMREAD));
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        m_cnt = 0;
        check("midrd_state", 64'(state), 64'(S_FETCH));
        check("midrd_memread", 64'(MemRead), 64'd1);
        check("midrd_regwrite", 64'(RegWrite), 64'd0);
        check_counts("midrd");
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 5)];
            run_instr(op, 1'b1, 0);
        end

        do_reset();
        for (int i = 0; i < 15; i++)
            run_instr(legal_ops[$urandom_range(0, 5)], 1'b1, 0);
        check("wrap_pre", 64'(d4_instr_count), 64'd15);
        run_instr(OP_J, 1'b0, 0);
        check("wrap_post4", 64'(d4_instr_count), 64'd0);
        check("wrap_post32", 64'(instr_count), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
